// File: rtl/sweep_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
package sweep_pkg;

    localparam int unsigned StepWidthDefault  = 48;
    localparam int unsigned CountWidthDefault = 16;
    localparam int unsigned DwellWidthDefault = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StDwell  = 2'd2,
        StFinish = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_controller_if.sv
// Control, configuration and AWG-facing signals of the sweep controller.
interface sweep_controller_if
    import sweep_pkg::*;
#(
    parameter int unsigned STEP_WIDTH  = StepWidthDefault,
    parameter int unsigned COUNT_WIDTH = CountWidthDefault,
    parameter int unsigned DWELL_WIDTH = DwellWidthDefault
) ();

    logic                   i_start;
    logic                   i_stop;
    logic                   i_repeat;
    logic [STEP_WIDTH-1:0]  i_start_step;
    logic [STEP_WIDTH-1:0]  i_step_increment;
    logic [COUNT_WIDTH-1:0] i_point_count;
    logic [DWELL_WIDTH-1:0] i_dwell_cycles;
    logic [STEP_WIDTH-1:0]  o_positive_signal_step;
    logic [STEP_WIDTH-1:0]  o_negative_signal_step;
    logic                   o_load_step_registers;
    logic                   o_busy;
    logic                   o_done;

    modport master (
        output i_start, i_stop, i_repeat, i_start_step, i_step_increment,
               i_point_count, i_dwell_cycles,
        input  o_positive_signal_step, o_negative_signal_step,
               o_load_step_registers, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop, i_repeat, i_start_step, i_step_increment,
               i_point_count, i_dwell_cycles,
        output o_positive_signal_step, o_negative_signal_step,
               o_load_step_registers, o_busy, o_done
    );

endinterface

// File: rtl/dwell_timer.sv
// Down-counter that times how long the sweep stays on one point.
module dwell_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_main_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_count_en,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_main_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_count_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Expires on the last dwell cycle so the FSM leaves DWELL on the same edge.
    assign o_expire = i_count_en && (r_count <= WIDTH'(1));

endmodule

// File: rtl/sweep_controller.sv
// Steps a DDS phase-step word through a linear sweep, strobing the AWG on each point.
module sweep_controller
    import sweep_pkg::*;
#(
    parameter int unsigned STEP_WIDTH  = StepWidthDefault,
    parameter int unsigned COUNT_WIDTH = CountWidthDefault,
    parameter int unsigned DWELL_WIDTH = DwellWidthDefault
) (
    input  logic              i_main_clk,
    input  logic              i_reset_n,
    sweep_controller_if.slave bus
);

    sweep_state_e           r_state;
    sweep_state_e           w_next_state;
    logic [STEP_WIDTH-1:0]  r_step;
    logic [STEP_WIDTH-1:0]  r_start_step;
    logic [STEP_WIDTH-1:0]  r_step_incr;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_index;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_repeat;
    logic                   r_load;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_expire;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_advance;
    logic [DWELL_WIDTH-1:0] w_dwell_load;

    assign w_last       = (r_index == r_count - COUNT_WIDTH'(1));
    assign w_accept     = (r_state == StIdle) && bus.i_start && !bus.i_stop &&
                          (bus.i_point_count != '0);
    assign w_advance    = (r_state == StDwell) && w_expire && !bus.i_stop;
    assign w_dwell_load = (r_dwell == '0) ? DWELL_WIDTH'(1) : r_dwell;

    dwell_timer #(
        .WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .i_main_clk  (i_main_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (r_state == StLoad),
        .i_load_value(w_dwell_load),
        .i_count_en  (r_state == StDwell),
        .o_expire    (w_expire)
    );

    always_ff @(posedge i_main_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle: begin
                if (bus.i_start && !bus.i_stop) begin
                    w_next_state = (bus.i_point_count != '0) ? StLoad : StFinish;
                end
            end
            StLoad:   w_next_state = StDwell;
            StDwell: begin
                if (w_expire) begin
                    w_next_state = (!w_last || r_repeat) ? StLoad : StFinish;
                end
            end
            StFinish: w_next_state = StIdle;
            default:  w_next_state = StIdle;
        endcase
        if ((r_state != StIdle) && bus.i_stop) begin
            w_next_state = StIdle;
        end
    end

    // Flags are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge i_main_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_step       <= '0;
            r_start_step <= '0;
            r_step_incr  <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_dwell      <= '0;
            r_repeat     <= 1'b0;
        end else begin
            r_load <= (w_next_state == StLoad);
            r_busy <= (w_next_state != StIdle);
            r_done <= (w_next_state == StFinish);
            if (w_accept) begin
                r_start_step <= bus.i_start_step;
                r_step_incr  <= bus.i_step_increment;
                r_count      <= bus.i_point_count;
                r_dwell      <= bus.i_dwell_cycles;
                r_repeat     <= bus.i_repeat;
                r_index      <= '0;
                r_step       <= bus.i_start_step;
            end else if (w_advance) begin
                if (!w_last) begin
                    r_step  <= r_step + r_step_incr;
                    r_index <= r_index + COUNT_WIDTH'(1);
                end else if (r_repeat) begin
                    r_step  <= r_start_step;
                    r_index <= '0;
                end
            end
        end
    end

    assign bus.o_positive_signal_step = r_step;
    assign bus.o_negative_signal_step = r_step;
    assign bus.o_load_step_registers  = r_load;
    assign bus.o_busy                 = r_busy;
    assign bus.o_done                 = r_done;

endmodule

// File: tb/tb_sweep_controller.sv
// Randomized self-checking bench for sweep_controller against an arithmetic sweep schedule.
module tb_sweep_controller;

    localparam int unsigned SW = 48;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [SW-1:0] last_step;

    sweep_controller_if #(
        .STEP_WIDTH (SW),
        .COUNT_WIDTH(CW),
        .DWELL_WIDTH(DW)
    ) bus_if ();

    sweep_controller #(
        .STEP_WIDTH (SW),
        .COUNT_WIDTH(CW),
        .DWELL_WIDTH(DW)
    ) dut (
        .i_main_clk(clk),
        .i_reset_n (rst_n),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_config();
        bus_if.i_start_step     = {16'($urandom), 32'($urandom)};
        bus_if.i_step_increment = {16'($urandom), 32'($urandom)};
        bus_if.i_point_count    = CW'($urandom);
        bus_if.i_dwell_cycles   = DW'($urandom);
        bus_if.i_repeat         = 1'($urandom);
    endtask

    // Expected outputs c cycles after start is sampled: point k is loaded at 1 + k*(D+1).
    function automatic void model(input int c, input logic [SW-1:0] st, input logic [SW-1:0] inc,
                                  input int cnt, input int dw, input logic rep,
                                  input logic [SW-1:0] prev, output logic ld, output logic dn,
                                  output logic bs, output logic [SW-1:0] stp);
        int d, p, k, r;
        ld = 1'b0; dn = 1'b0; bs = 1'b0; stp = prev;
        if (cnt == 0) begin
            if (c == 1) begin dn = 1'b1; bs = 1'b1; end
            return;
        end
        d = (dw == 0) ? 1 : dw;
        p = d + 1;
        k = (c - 1) / p;
        r = (c - 1) % p;
        if (!rep && k >= cnt) begin
            stp = st + SW'(cnt - 1) * inc;
            if (k == cnt && r == 0) begin dn = 1'b1; bs = 1'b1; end
            return;
        end
        bs  = 1'b1;
        ld  = (r == 0);
        stp = st + SW'(k % cnt) * inc;
    endfunction

    task automatic run_sweep(input logic [SW-1:0] st, input logic [SW-1:0] inc, input int cnt,
                             input int dw, input logic rep, input int stop_at,
                             output int n_strobes, output int done_cycle);
        int n;
        logic ld, dn, bs, e_ld, e_dn, e_bs;
        logic [SW-1:0] stp, e_stp, stop_stp;
        logic [SW-1:0] prev;
        prev = last_step;
        n_strobes = 0;
        done_cycle = -1;
        if (stop_at > 0) n = stop_at + 2;
        else if (cnt == 0) n = 3;
        else n = 1 + cnt * (((dw == 0) ? 1 : dw) + 1) + 2;
        stop_stp = prev;
        if (stop_at > 0) model(stop_at, st, inc, cnt, dw, rep, prev, ld, dn, bs, stop_stp);
        bus_if.i_start_step     = st;
        bus_if.i_step_increment = inc;
        bus_if.i_point_count    = CW'(cnt);
        bus_if.i_dwell_cycles   = DW'(dw);
        bus_if.i_repeat         = rep;
        bus_if.i_stop           = 1'b0;
        bus_if.i_start          = 1'b1;
        for (int c = 1; c <= n; c++) begin
            tick();
            model(c, st, inc, cnt, dw, rep, prev, e_ld, e_dn, e_bs, e_stp);
            if (stop_at > 0 && c > stop_at) begin
                e_ld = 1'b0; e_dn = 1'b0; e_bs = 1'b0; e_stp = stop_stp;
            end
            if (bus_if.o_load_step_registers) n_strobes++;
            if (bus_if.o_done && done_cycle < 0) done_cycle = c;
            n_checks += 5;
            if (bus_if.o_load_step_registers !== e_ld) begin
                n_errors++;
                $display("FAIL sweep c%0d load: got %b want %b", c, bus_if.o_load_step_registers, e_ld);
            end
            if (bus_if.o_done !== e_dn) begin
                n_errors++;
                $display("FAIL sweep c%0d done: got %b want %b", c, bus_if.o_done, e_dn);
            end
            if (bus_if.o_busy !== e_bs) begin
                n_errors++;
                $display("FAIL sweep c%0d busy: got %b want %b", c, bus_if.o_busy, e_bs);
            end
            if (bus_if.o_positive_signal_step !== e_stp) begin
                n_errors++;
                $display("FAIL sweep c%0d pos_step: got %h want %h", c,
                         bus_if.o_positive_signal_step, e_stp);
            end
            if (bus_if.o_negative_signal_step !== e_stp) begin
                n_errors++;
                $display("FAIL sweep c%0d neg_step: got %h want %h", c,
                         bus_if.o_negative_signal_step, e_stp);
            end
            last_step = e_stp;
            // While busy, a fresh start and new configuration must both be ignored.
            randomize_config();
            bus_if.i_start = e_bs && (c != stop_at) && 1'($urandom);
            bus_if.i_stop  = (c == stop_at);
        end
        bus_if.i_start = 1'b0;
        bus_if.i_stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.i_start = 1'b0;
        bus_if.i_stop  = 1'b0;
        randomize_config();
        tick();
        tick();
        n_checks += 5;
        if (bus_if.o_positive_signal_step !== '0) begin
            n_errors++; $display("FAIL reset pos_step: got %h want 0", bus_if.o_positive_signal_step);
        end
        if (bus_if.o_negative_signal_step !== '0) begin
            n_errors++; $display("FAIL reset neg_step: got %h want 0", bus_if.o_negative_signal_step);
        end
        if (bus_if.o_load_step_registers !== 1'b0) begin
            n_errors++; $display("FAIL reset load: got %b want 0", bus_if.o_load_step_registers);
        end
        if (bus_if.o_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset busy: got %b want 0", bus_if.o_busy);
        end
        if (bus_if.o_done !== 1'b0) begin
            n_errors++; $display("FAIL reset done: got %b want 0", bus_if.o_done);
        end
        rst_n = 1'b1;
        last_step = '0;
        tick();
    endtask

    task automatic test_basic();
        int ns, dc;
        run_sweep(48'h100, 48'h10, 3, 4, 1'b0, 0, ns, dc);
        n_checks += 3;
        if (ns !== 3) begin
            n_errors++; $display("FAIL basic strobe_count: got %0d want 3", ns);
        end
        if (dc !== 16) begin
            n_errors++; $display("FAIL basic done_cycle: got %0d want 16", dc);
        end
        if (bus_if.o_positive_signal_step !== 48'h120) begin
            n_errors++; $display("FAIL basic final_step: got %h want 120", bus_if.o_positive_signal_step);
        end
    endtask

    task automatic test_wrap();
        int ns, dc;
        run_sweep(48'hFFFF_FFFF_FFF8, 48'h10, 2, $urandom_range(0, 3), 1'b0, 0, ns, dc);
        n_checks++;
        if (bus_if.o_positive_signal_step !== 48'h8) begin
            n_errors++; $display("FAIL wrap step: got %h want 8", bus_if.o_positive_signal_step);
        end
    endtask

    task automatic test_repeat();
        int ns, dc;
        run_sweep(48'h4000, 48'h123, 2, 0, 1'b1, 13, ns, dc);
        n_checks += 2;
        if (dc !== -1) begin
            n_errors++; $display("FAIL repeat done_seen: got cycle %0d want none", dc);
        end
        if (ns !== 7) begin
            n_errors++; $display("FAIL repeat strobe_count: got %0d want 7", ns);
        end
    endtask

    task automatic test_stop();
        int ns, dc;
        // Point 2 loads at cycle 5 and dwells in cycles 6..8; stop is sampled in cycle 7.
        run_sweep(48'h2000, 48'h40, 4, 3, 1'b0, 7, ns, dc);
        n_checks += 3;
        if (ns !== 2) begin
            n_errors++; $display("FAIL stop strobe_count: got %0d want 2", ns);
        end
        if (dc !== -1) begin
            n_errors++; $display("FAIL stop done_seen: got cycle %0d want none", dc);
        end
        if (bus_if.o_positive_signal_step !== 48'h2040) begin
            n_errors++; $display("FAIL stop held_step: got %h want 2040", bus_if.o_positive_signal_step);
        end
    endtask

    task automatic test_zero_and_start_stop();
        int ns, dc;
        run_sweep(48'h777, 48'h1, 0, 2, 1'b0, 0, ns, dc);
        n_checks += 2;
        if (ns !== 0) begin
            n_errors++; $display("FAIL zero_count strobes: got %0d want 0", ns);
        end
        if (dc !== 1) begin
            n_errors++; $display("FAIL zero_count done_cycle: got %0d want 1", dc);
        end
        bus_if.i_start_step  = 48'h999;
        bus_if.i_point_count = 16'd3;
        bus_if.i_start       = 1'b1;
        bus_if.i_stop        = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus_if.i_start = 1'b0;
            bus_if.i_stop  = 1'b0;
            n_checks += 3;
            if (bus_if.o_busy !== 1'b0) begin
                n_errors++; $display("FAIL start_stop c%0d busy: got %b want 0", c, bus_if.o_busy);
            end
            if (bus_if.o_load_step_registers !== 1'b0) begin
                n_errors++;
                $display("FAIL start_stop c%0d load: got %b want 0", c, bus_if.o_load_step_registers);
            end
            if (bus_if.o_positive_signal_step !== last_step) begin
                n_errors++; $display("FAIL start_stop c%0d step: got %h want %h", c,
                                     bus_if.o_positive_signal_step, last_step);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int ns, dc;
        bus_if.i_start_step     = 48'h5000;
        bus_if.i_step_increment = 48'h8;
        bus_if.i_point_count    = 16'd5;
        bus_if.i_dwell_cycles   = 32'd4;
        bus_if.i_repeat         = 1'b0;
        bus_if.i_start          = 1'b1;
        tick();
        bus_if.i_start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (bus_if.o_positive_signal_step !== '0) begin
            n_errors++; $display("FAIL midreset step: got %h want 0", bus_if.o_positive_signal_step);
        end
        if (bus_if.o_busy !== 1'b0) begin
            n_errors++; $display("FAIL midreset busy: got %b want 0", bus_if.o_busy);
        end
        if (bus_if.o_load_step_registers !== 1'b0) begin
            n_errors++; $display("FAIL midreset load: got %b want 0", bus_if.o_load_step_registers);
        end
        if (bus_if.o_done !== 1'b0) begin
            n_errors++; $display("FAIL midreset done: got %b want 0", bus_if.o_done);
        end
        tick();
        rst_n = 1'b1;
        last_step = '0;
        tick();
        n_checks += 2;
        if (bus_if.o_busy !== 1'b0) begin
            n_errors++; $display("FAIL postreset busy: got %b want 0", bus_if.o_busy);
        end
        if (bus_if.o_load_step_registers !== 1'b0) begin
            n_errors++; $display("FAIL postreset load: got %b want 0", bus_if.o_load_step_registers);
        end
        run_sweep(48'h5000, 48'h8, 3, 2, 1'b0, 0, ns, dc);
    endtask

    task automatic test_random();
        int ns, dc, cnt, dw, stop_at;
        logic rep;
        for (int i = 0; i < 8; i++) begin
            cnt = $urandom_range(0, 4);
            dw  = $urandom_range(0, 5);
            rep = 1'($urandom);
            stop_at = rep ? $urandom_range(1, 24) : (($urandom_range(0, 2) == 0) ?
                                                      $urandom_range(1, 12) : 0);
            run_sweep({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                      cnt, dw, rep, stop_at, ns, dc);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_step = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_repeat();
        test_stop();
        test_zero_and_start_stop();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sweep_controller.md
SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 Parameter STEP_WIDTH, default 48: width of the DDS phase-step words.
REQ-002 Parameter COUNT_WIDTH, default 16: width of the sweep point counter.
REQ-003 Parameter DWELL_WIDTH, default 32: width of the dwell timer.
REQ-004 Port i_main_clk, input, 1: single core clock; all logic is rising-edge.
REQ-005 Port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port i_start, input, 1: one-cycle request to begin a sweep.
REQ-007 Port i_stop, input, 1: one-cycle request to abort the sweep.
REQ-008 Port i_repeat, input, 1: 0 = single sweep, 1 = restart from the first point after the last point.
REQ-009 Port i_start_step, input, STEP_WIDTH: phase step of the first point.
REQ-010 Port i_step_increment, input, STEP_WIDTH: phase-step delta between consecutive points.
REQ-011 Port i_point_count, input, COUNT_WIDTH: number of points per sweep.
REQ-012 Port i_dwell_cycles, input, DWELL_WIDTH: clocks spent on each point.
REQ-013 Port o_positive_signal_step, output, STEP_WIDTH: step word driven to the AWG.
REQ-014 Port o_negative_signal_step, output, STEP_WIDTH: step word driven to the AWG, always equal to o_positive_signal_step.
REQ-015 Port o_load_step_registers, output, 1: one-cycle strobe telling the AWG to latch the step words.
REQ-016 Port o_busy, output, 1: high while the FSM is outside IDLE.
REQ-017 Port o_done, output, 1: one-cycle pulse when a single sweep completes.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, DWELL and FINISH.
REQ-019 In IDLE, i_start=1 with i_point_count!=0 SHALL latch all i_* configuration inputs, set the point index to 0, set the step to i_start_step and enter LOAD on the next cycle.
REQ-020 In IDLE, i_start=1 with i_point_count=0 SHALL enter FINISH without generating any load strobe.
REQ-021 LOAD SHALL last exactly one cycle, SHALL assert o_load_step_registers with the new step on both step outputs in that same cycle, SHALL reload the dwell timer, and SHALL then enter DWELL.
REQ-022 The first load strobe SHALL occur 1 cycle after i_start is sampled.
REQ-023 DWELL SHALL last max(dwell,1) cycles, so a dwell of 0 behaves as a dwell of 1.
REQ-024 At the end of DWELL, if index < count-1, the block SHALL set step = step + increment modulo 2^STEP_WIDTH (wrap, no saturation), increment the index and enter LOAD.
REQ-025 At the end of DWELL on the last point, with latched repeat=1, the block SHALL set index=0, set step to the latched start step and enter LOAD.
REQ-026 At the end of DWELL on the last point, with latched repeat=0, the block SHALL enter FINISH.
REQ-027 FINISH SHALL last one cycle, SHALL assert o_done, and SHALL return to IDLE.
REQ-028 Point-to-point spacing between load strobes SHALL be max(dwell,1)+1 cycles.
REQ-029 i_start SHALL be ignored while o_busy=1, and configuration changes during a sweep SHALL have no effect.
REQ-030 i_stop=1 in any non-IDLE state SHALL force IDLE on the next cycle, with no load strobe, no o_done, and the step outputs holding their last value.
REQ-031 If i_start and i_stop are both high in IDLE, stop SHALL win and the block SHALL remain in IDLE.
REQ-032 o_busy SHALL be high in LOAD, DWELL and FINISH, and low in IDLE.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 Asserting i_reset_n=0 SHALL immediately force state IDLE, both step outputs to 0, o_load_step_registers=0, o_busy=0, o_done=0, index=0 and dwell timer=0.
REQ-035 Reset asserted mid-sweep SHALL abort without emitting a strobe, and the first cycle after release SHALL be IDLE.

Structure
REQ-036 The state encoding and the default widths (48/16/32) SHALL reside in a shared package, sweep_pkg.
REQ-037 The dwell timer SHALL be one sub-module, dwell_timer, with load, count-down and expire signals.
REQ-038 The remainder of the design SHALL be flat.

Verification
REQ-039 Scenario: start_step=0x100, incr=0x10, count=3, dwell=4, repeat=0 -> strobes at cycles 1, 6, 11 with steps 0x100/0x110/0x120; o_done at cycle 16.
REQ-040 Scenario: start_step=0xFFFF_FFFF_FFF8, incr=0x10, count=2 -> second step = 0x8 (wrap).
REQ-041 Scenario: repeat=1, count=2, dwell=0 -> strobes every 2 cycles with steps alternating start/start+incr; no o_done.
REQ-042 Scenario: i_stop in the DWELL of point 2 -> o_busy low on the next cycle, no further strobes, step holds point 2 value.
REQ-043 Scenario: count=0 with start -> o_done 1 cycle later, zero strobes; and i_start+i_stop in the same cycle -> nothing happens.
REQ-044 Scenario: i_reset_n pulsed low during DWELL -> all outputs 0 asynchronously; a new i_start after release sweeps normally.
